colour_lookup_arbiter: RTL

Shares the single-port 8-entry colour-to-RGB ROM between two requesters, for example a display path and an LED path. Requests use a valid/ready handshake. The block performs round-robin arbitration, drives the ROM enable and address, and waits out the ROM read latency. It then returns the 24-bit RGB word to the requester that was granted, over a response valid/ready handshake. Only one lookup is in flight at a time; lookups are not pipelined.

---
 rtl/colour_pkg.sv | 50 +++++
 rtl/rr_arb2.sv | 51 +++++
 rtl/colour_lookup_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/colour_pkg.sv
// Shared types and constants for the colour lookup arbiter: FSM states,
// field widths and the 3-bit colour code to 24-bit RGB table.
package colour_pkg;

    localparam int RGB_W    = 24;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Colour codes: bit 2 = red, bit 1 = green, bit 0 = blue.
    localparam logic [COLOUR_W-1:0] COL_BLACK   = 3'd0;
    localparam logic [COLOUR_W-1:0] COL_BLUE    = 3'd1;
    localparam logic [COLOUR_W-1:0] COL_GREEN   = 3'd2;
    localparam logic [COLOUR_W-1:0] COL_CYAN    = 3'd3;
    localparam logic [COLOUR_W-1:0] COL_RED     = 3'd4;
    localparam logic [COLOUR_W-1:0] COL_MAGENTA = 3'd5;
    localparam logic [COLOUR_W-1:0] COL_YELLOW  = 3'd6;
    localparam logic [COLOUR_W-1:0] COL_WHITE   = 3'd7;

    localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
    localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;

    // Reference contents of the colour ROM, one entry per code.
    function automatic logic [RGB_W-1:0] colour_rgb(input logic [COLOUR_W-1:0] code);
        logic [RGB_W-1:0] rgb;
        case (code)
            COL_BLACK:   rgb = RGB_BLACK;
            COL_BLUE:    rgb = RGB_BLUE;
            COL_GREEN:   rgb = RGB_GREEN;
            COL_CYAN:    rgb = RGB_CYAN;
            COL_RED:     rgb = RGB_RED;
            COL_MAGENTA: rgb = RGB_MAGENTA;
            COL_YELLOW:  rgb = RGB_YELLOW;
            default:     rgb = RGB_WHITE;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointer decides, and every accepted grant hands priority to the other side.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o,
    output logic       gnt_id_o,
    output logic       accept_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant decode: at most one bit set, and only while arbitration is enabled.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        grant_o = 2'b00;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

    assign gnt_id_o = grant_o[1];
    assign accept_o = |(grant_o & valid_i);

    // Pointer next state: point at the requester that was not just served.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_o) begin
            ptr_d = ~gnt_id_o;
        end
    end

    // Pointer register; requester 0 has priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/colour_lookup_arbiter.sv
// Shares a single-port colour ROM between two requesters. One lookup at a
// time: arbitrate, drive the ROM, wait out its latency, then hold the RGB
// result on the granted requester's response port until it is taken.
module colour_lookup_arbiter
    import colour_pkg::*;
#(
    parameter int ROM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    input  logic [COLOUR_W-1:0] req0_colour,
    output logic                req0_ready,
    output logic                rsp0_valid,
    output logic [RGB_W-1:0]    rsp0_rgb,
    input  logic                rsp0_ready,

    input  logic                req1_valid,
    input  logic [COLOUR_W-1:0] req1_colour,
    output logic                req1_ready,
    output logic                rsp1_valid,
    output logic [RGB_W-1:0]    rsp1_rgb,
    input  logic                rsp1_ready,

    output logic                rom_en,
    output logic [COLOUR_W-1:0] rom_addr,
    input  logic [RGB_W-1:0]    rom_rgb,

    output logic                busy
);

    // Latency counter covers ROM_LATENCY-1 in the legal range 1..4.
    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LATENCY - 1);

    state_e              state_q,     state_d;
    logic                id_q,        id_d;
    logic                rom_en_q,    rom_en_d;
    logic [COLOUR_W-1:0] rom_addr_q,  rom_addr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [RGB_W-1:0]    rsp0_rgb_q,  rsp0_rgb_d;
    logic [RGB_W-1:0]    rsp1_rgb_q,  rsp1_rgb_d;

    logic                arb_en;
    logic [1:0]          grant;
    logic                gnt_id;
    logic                accept;
    logic                rsp_taken;

    // Requests are only considered in IDLE, and never while reset is held,
    // so both ready outputs read 0 during reset even with valid requests.
    assign arb_en = rst_n && (state_q == IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (arb_en),
        .valid_i  ({req1_valid, req0_valid}),
        .grant_o  (grant),
        .gnt_id_o (gnt_id),
        .accept_o (accept)
    );

    assign rsp_taken = (rsp_valid_q[0] && rsp0_ready) || (rsp_valid_q[1] && rsp1_ready);

    // Next-state and datapath decode for the lookup sequence.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rom_en_d    = rom_en_q;
        rom_addr_d  = rom_addr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp0_rgb_d  = rsp0_rgb_q;
        rsp1_rgb_d  = rsp1_rgb_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d       = gnt_id;
                    rom_addr_d = gnt_id ? req1_colour : req0_colour;
                    rom_en_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                // Enable and address stay put so a registered-output ROM keeps running.
                if (cnt_q == '0) begin
                    if (id_q) begin
                        rsp1_rgb_d     = rom_rgb;
                        rsp_valid_d[1] = 1'b1;
                    end else begin
                        rsp0_rgb_d     = rom_rgb;
                        rsp_valid_d[0] = 1'b1;
                    end
                    rom_en_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESP: begin
                if (rsp_taken) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; a reset drops any lookup in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp0_rgb_q  <= '0;
            rsp1_rgb_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_rgb_q  <= rsp0_rgb_d;
            rsp1_rgb_q  <= rsp1_rgb_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rgb   = rsp0_rgb_q;
    assign rsp1_rgb   = rsp1_rgb_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign busy       = (state_q != IDLE);

endmodule
